// File: rtl/tile_config_sequencer.sv
// Per-tile configuration sequencer. It buffers config bus beats, keeps those addressed to this tile,
// and issues one target strobe per decoded write, followed by a settle window.
module tile_config_sequencer #(
    parameter int          FIFO_DEPTH    = 4,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] BROADCAST_ID  = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_tile_id,
    input  logic        i_config_valid,
    output logic        o_config_ready,
    input  logic [31:0] i_config_addr,
    input  logic [31:0] i_config_data,
    output logic        o_config_en_pe,
    output logic        o_config_en_sb,
    output logic        o_config_en_cb0,
    output logic        o_config_en_cb1,
    output logic [7:0]  o_config_reg,
    output logic [31:0] o_config_wdata,
    output logic        o_busy,
    output logic [7:0]  o_err_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE
    } seqState_t;

    logic [63:0]   r_fifoMem [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_readyEn;
    seqState_t     r_state;
    logic [SW-1:0] r_settleCnt;
    logic [1:0]    r_pendTarget;
    logic [7:0]    r_pendReg;
    logic [31:0]   r_pendData;

    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;
    logic          w_tileMatch;
    logic          w_targetOk;

    // Ready depends only on registered state, so there is no combinational path from valid.
    assign o_config_ready = r_readyEn && (r_count != FULL_COUNT);
    assign w_push         = i_config_valid && o_config_ready;
    assign w_pop          = (r_state == IDLE) && (r_count != '0);
    assign w_head         = r_fifoMem[r_rdPtr];
    assign w_tileMatch    = (w_head[63:48] == i_tile_id) || (w_head[63:48] == BROADCAST_ID);
    assign w_targetOk     = (w_head[47:40] < 8'd4);
    assign o_busy         = (r_count != '0) || (r_state != IDLE);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= {i_config_addr, i_config_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_readyEn <= 1'b0;
        end else begin
            r_readyEn <= 1'b1;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Every beat is popped in IDLE; only beats that match this tile with a known target reach ISSUE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_settleCnt     <= '0;
            r_pendTarget    <= 2'd0;
            r_pendReg       <= 8'd0;
            r_pendData      <= 32'd0;
            o_config_en_pe  <= 1'b0;
            o_config_en_sb  <= 1'b0;
            o_config_en_cb0 <= 1'b0;
            o_config_en_cb1 <= 1'b0;
            o_config_reg    <= 8'd0;
            o_config_wdata  <= 32'd0;
            o_err_count     <= 8'd0;
        end else begin
            o_config_en_pe  <= 1'b0;
            o_config_en_sb  <= 1'b0;
            o_config_en_cb0 <= 1'b0;
            o_config_en_cb1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop && w_tileMatch) begin
                        if (w_targetOk) begin
                            r_pendTarget <= w_head[41:40];
                            r_pendReg    <= w_head[39:32];
                            r_pendData   <= w_head[31:0];
                            r_state      <= ISSUE;
                        end else if (o_err_count != 8'hFF) begin
                            o_err_count <= o_err_count + 8'd1;
                        end
                    end
                end
                ISSUE: begin
                    o_config_en_pe  <= (r_pendTarget == 2'd0);
                    o_config_en_sb  <= (r_pendTarget == 2'd1);
                    o_config_en_cb0 <= (r_pendTarget == 2'd2);
                    o_config_en_cb1 <= (r_pendTarget == 2'd3);
                    o_config_reg    <= r_pendReg;
                    o_config_wdata  <= r_pendData;
                    if (SETTLE_CYCLES > 0) begin
                        r_settleCnt <= SW'(SETTLE_CYCLES);
                        r_state     <= SETTLE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SETTLE: begin
                    r_settleCnt <= r_settleCnt - SW'(1);
                    if (r_settleCnt == SW'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_config_sequencer.sv
// Bench for tile_config_sequencer: two instances (settle 2 and settle 0) checked every cycle
// against a timing-rule model, plus directed literal checks.
module tb_tile_config_sequencer;

    localparam int N     = 4096;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic [15:0] tileId [2];
    logic        vld    [2];
    logic [31:0] addr   [2];
    logic [31:0] data   [2];
    logic        rdy    [2];
    logic        enPe   [2];
    logic        enSb   [2];
    logic        enCb0  [2];
    logic        enCb1  [2];
    logic [7:0]  creg   [2];
    logic [31:0] wdata  [2];
    logic        busy   [2];
    logic [7:0]  err    [2];

    tile_config_sequencer #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(2), .BROADCAST_ID(16'hFFFF)) dut0 (
        .i_clk(clk), .i_reset(rst[0]), .i_tile_id(tileId[0]),
        .i_config_valid(vld[0]), .o_config_ready(rdy[0]),
        .i_config_addr(addr[0]), .i_config_data(data[0]),
        .o_config_en_pe(enPe[0]), .o_config_en_sb(enSb[0]),
        .o_config_en_cb0(enCb0[0]), .o_config_en_cb1(enCb1[0]),
        .o_config_reg(creg[0]), .o_config_wdata(wdata[0]),
        .o_busy(busy[0]), .o_err_count(err[0])
    );

    tile_config_sequencer #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(0), .BROADCAST_ID(16'hFFFF)) dut1 (
        .i_clk(clk), .i_reset(rst[1]), .i_tile_id(tileId[1]),
        .i_config_valid(vld[1]), .o_config_ready(rdy[1]),
        .i_config_addr(addr[1]), .i_config_data(data[1]),
        .o_config_en_pe(enPe[1]), .o_config_en_sb(enSb[1]),
        .o_config_en_cb0(enCb0[1]), .o_config_en_cb1(enCb1[1]),
        .o_config_reg(creg[1]), .o_config_wdata(wdata[1]),
        .o_busy(busy[1]), .o_err_count(err[1])
    );

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    bit checkOn    = 1'b0;

    // Model state: per instance, events scheduled by edge number when each beat is accepted.
    int          settleOf [2] = '{2, 0};
    logic [3:0]  mStrobe  [2][N];
    logic [7:0]  mReg     [2][N];
    logic [31:0] mData    [2][N];
    bit          popAt    [2][N];
    bit          errAt    [2][N];
    bit          activeAt [2][N];
    int          occ      [2];
    int          freeAt   [2];
    bit          readyEn  [2];
    bit          expReady [2];
    bit          expBusy  [2];
    logic [3:0]  expStrobe[2];
    logic [7:0]  expReg   [2];
    logic [31:0] expData  [2];
    logic [7:0]  expErr   [2];
    int          mP;
    bit          mAccept;
    bit          mTileOk;

    int          q0Cyc[$];
    logic [31:0] q0Data[$];
    logic [3:0]  q0Tgt[$];
    int          q1Cyc[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input int u, input logic [31:0] a, input logic [31:0] d,
                                 output int acceptCyc);
        int waitCnt;
        waitCnt = 0;
        vld[u]  = 1'b1;
        addr[u] = a;
        data[u] = d;
        while (rdy[u] !== 1'b1 && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        if (rdy[u] !== 1'b1) begin
            assertions++;
            failures++;
            $display("[TB] FAIL handshake timeout u%0d: ready=%b, expected 1", u, rdy[u]);
        end
        @(negedge clk);
        acceptCyc = cyc;
        vld[u]    = 1'b0;
    endtask

    task automatic waitCyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Beat accepted at edge k pops at max(k+1, free); a valid write strobes one edge after its pop,
    // keeps the sequencer non-idle for 1+settle cycles, and frees it two edges plus settle later.
    always @(posedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (rst[u]) begin
                occ[u]       = 0;
                freeAt[u]    = cyc + 1;
                readyEn[u]   = 1'b0;
                expStrobe[u] = 4'd0;
                expReg[u]    = 8'd0;
                expData[u]   = 32'd0;
                expErr[u]    = 8'd0;
                for (int j = cyc; j < N; j++) begin
                    mStrobe[u][j]  = 4'd0;
                    popAt[u][j]    = 1'b0;
                    errAt[u][j]    = 1'b0;
                    activeAt[u][j] = 1'b0;
                end
            end else begin
                mAccept = vld[u] && expReady[u];
                if (mAccept) begin
                    mP = (cyc + 1 > freeAt[u]) ? cyc + 1 : freeAt[u];
                    if (mP + settleOf[u] + 2 >= N) begin
                        $display("[TB] FAIL model horizon exceeded at cycle %0d", cyc);
                        $fatal(1, "[TB] model horizon exceeded");
                    end
                    mTileOk = (addr[u][31:16] == tileId[u]) || (addr[u][31:16] == 16'hFFFF);
                    popAt[u][mP] = 1'b1;
                    if (!mTileOk) begin
                        freeAt[u] = mP + 1;
                    end else if (addr[u][15:8] > 8'd3) begin
                        errAt[u][mP] = 1'b1;
                        freeAt[u]    = mP + 1;
                    end else begin
                        mStrobe[u][mP + 1] = 4'b0001 << addr[u][9:8];
                        mReg[u][mP + 1]    = addr[u][7:0];
                        mData[u][mP + 1]   = data[u];
                        for (int j = mP; j <= mP + settleOf[u]; j++) activeAt[u][j] = 1'b1;
                        freeAt[u] = mP + 2 + settleOf[u];
                    end
                end
                occ[u] = occ[u] + (mAccept ? 1 : 0) - (popAt[u][cyc] ? 1 : 0);
                if (errAt[u][cyc] && expErr[u] != 8'hFF) expErr[u] = expErr[u] + 8'd1;
                expStrobe[u] = mStrobe[u][cyc];
                if (expStrobe[u] != 4'd0) begin
                    expReg[u]  = mReg[u][cyc];
                    expData[u] = mData[u][cyc];
                end
                readyEn[u] = 1'b1;
            end
            expReady[u] = readyEn[u] && (occ[u] < DEPTH);
            expBusy[u]  = (occ[u] > 0) || activeAt[u][cyc];
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            for (int u = 0; u < 2; u++) begin
                checkOutput($sformatf("u%0d strobes", u),
                            {28'd0, enCb1[u], enCb0[u], enSb[u], enPe[u]}, {28'd0, expStrobe[u]});
                checkOutput($sformatf("u%0d ready", u), {31'd0, rdy[u]}, {31'd0, expReady[u]});
                checkOutput($sformatf("u%0d busy", u), {31'd0, busy[u]}, {31'd0, expBusy[u]});
                checkOutput($sformatf("u%0d reg", u), {24'd0, creg[u]}, {24'd0, expReg[u]});
                checkOutput($sformatf("u%0d wdata", u), wdata[u], expData[u]);
                checkOutput($sformatf("u%0d err_count", u), {24'd0, err[u]}, {24'd0, expErr[u]});
            end
            if ({enCb1[0], enCb0[0], enSb[0], enPe[0]} != 4'd0) begin
                q0Cyc.push_back(cyc);
                q0Data.push_back(wdata[0]);
                q0Tgt.push_back({enCb1[0], enCb0[0], enSb[0], enPe[0]});
            end
            if ({enCb1[1], enCb0[1], enSb[1], enPe[1]} != 4'd0) q1Cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        assertions++;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        int k;
        int k2;
        int n;
        int acc[6];

        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; tileId[u] = 16'h0005; vld[u] = 1'b0; addr[u] = 32'd0; data[u] = 32'd0;
            expReady[u] = 1'b0;
        end

        // Reset state
        @(negedge clk);
        checkOn = 1'b1;
        checkOutput("reset ready", {31'd0, rdy[0]}, 32'd0);
        checkOutput("reset busy", {31'd0, busy[0]}, 32'd0);
        checkOutput("reset err", {24'd0, err[0]}, 32'd0);
        checkOutput("reset strobe", {31'd0, enPe[0]}, 32'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        waitCyc(cyc + 2);
        checkOutput("ready after reset", {31'd0, rdy[0]}, 32'd1);

        // Single write to the switch box
        n = q0Cyc.size();
        applyStimulus(0, 32'h0005_0100, 32'hDEAD_BEEF, k);
        waitCyc(k + 2);
        checkOutput("single sb strobe", {31'd0, enSb[0]}, 32'd1);
        checkOutput("single pe idle", {31'd0, enPe[0]}, 32'd0);
        checkOutput("single reg", {24'd0, creg[0]}, 32'h00);
        checkOutput("single wdata", wdata[0], 32'hDEAD_BEEF);
        waitCyc(k + 3);
        checkOutput("single strobe drop", {31'd0, enSb[0]}, 32'd0);
        waitCyc(k + 8);
        checkOutput("single pulse count", q0Cyc.size() - n, 32'd1);

        // Foreign tile is dropped, broadcast goes to cb1
        n = q0Cyc.size();
        applyStimulus(0, 32'h0007_0000, 32'h1111_1111, k);
        applyStimulus(0, 32'hFFFF_0312, 32'h2222_2222, k2);
        waitCyc(k2 + 10);
        checkOutput("filter pulse count", q0Cyc.size() - n, 32'd1);
        if (q0Cyc.size() > n) begin
            checkOutput("filter target", {28'd0, q0Tgt[n]}, 32'h8);
            checkOutput("filter data", q0Data[n], 32'h2222_2222);
        end
        checkOutput("filter reg", {24'd0, creg[0]}, 32'h12);
        checkOutput("filter err", {24'd0, err[0]}, 32'd0);

        // Bad target counting and saturation
        n = q0Cyc.size();
        applyStimulus(0, 32'h0005_0700, 32'd0, k);
        waitCyc(k + 3);
        checkOutput("bad target err 1", {24'd0, err[0]}, 32'd1);
        for (int i = 1; i < 300; i++) applyStimulus(0, 32'h0005_0700, i, k);
        waitCyc(k + 4);
        checkOutput("bad target err 255", {24'd0, err[0]}, 32'd255);
        for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0005_0700, i, k);
        waitCyc(k + 4);
        checkOutput("bad target err hold", {24'd0, err[0]}, 32'd255);
        checkOutput("bad target no strobe", q0Cyc.size() - n, 32'd0);

        // Backpressure with six back-to-back PE writes
        waitCyc(cyc + 5);
        n = q0Cyc.size();
        for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0005_0000 | i, 32'h100 + i, acc[i]);
        waitCyc(acc[0] + 30);
        checkOutput("bp first four back to back", acc[4] - acc[0], 32'd4);
        checkOutput("bp sixth accept stalled", acc[5] - acc[0], 32'd6);
        checkOutput("bp pulse count", q0Cyc.size() - n, 32'd6);
        if (q0Cyc.size() >= n + 6) begin
            for (int i = 0; i < 6; i++) begin
                checkOutput($sformatf("bp pulse %0d cycle", i), q0Cyc[n + i], acc[0] + 2 + 4 * i);
                checkOutput($sformatf("bp pulse %0d data", i), q0Data[n + i], 32'h100 + i);
                checkOutput($sformatf("bp pulse %0d target", i), {28'd0, q0Tgt[n + i]}, 32'h1);
            end
        end

        // Zero settle: pulses two cycles apart, busy drops with the last strobe
        n = q1Cyc.size();
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h0005_0020 + i, 32'hC0DE_0000 + i, acc[i]);
        waitCyc(acc[0] + 5);
        checkOutput("s0 busy before last strobe", {31'd0, busy[1]}, 32'd1);
        waitCyc(acc[0] + 6);
        checkOutput("s0 busy at last strobe", {31'd0, busy[1]}, 32'd0);
        checkOutput("s0 last strobe", {31'd0, enPe[1]}, 32'd1);
        waitCyc(acc[0] + 12);
        checkOutput("s0 pulse count", q1Cyc.size() - n, 32'd3);
        if (q1Cyc.size() >= n + 3) begin
            for (int i = 0; i < 3; i++)
                checkOutput($sformatf("s0 pulse %0d cycle", i), q1Cyc[n + i], acc[0] + 2 + 2 * i);
        end

        // Reset while the first strobe is high
        waitCyc(cyc + 5);
        n = q0Cyc.size();
        applyStimulus(0, 32'h0005_0001, 32'hAAAA_0001, k);
        applyStimulus(0, 32'h0005_0002, 32'hAAAA_0002, k2);
        applyStimulus(0, 32'h0005_0003, 32'hAAAA_0003, k2);
        waitCyc(k + 2);
        checkOutput("mid reset strobe before", {31'd0, enPe[0]}, 32'd1);
        rst[0] = 1'b1;
        waitCyc(k + 3);
        checkOutput("mid reset strobe cleared", {31'd0, enPe[0]}, 32'd0);
        rst[0] = 1'b0;
        waitCyc(k + 5);
        checkOutput("post reset ready", {31'd0, rdy[0]}, 32'd1);
        checkOutput("post reset busy", {31'd0, busy[0]}, 32'd0);
        checkOutput("post reset err", {24'd0, err[0]}, 32'd0);
        waitCyc(k + 30);
        checkOutput("post reset pulse count", q0Cyc.size() - n, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
